// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter: NREQ valid/ready sources share one regfile write port
// through a single registered output stage. Optional forwarding ports under `WB_FWD_EN`.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_stall,
    input  logic [NREQ-1:0]      i_req_valid,
    input  logic [NREQ*AW-1:0]   i_req_addr,
    input  logic [NREQ*DW-1:0]   i_req_data,
    output logic [NREQ-1:0]      o_req_ready,
`ifdef WB_FWD_EN
    input  logic [AW-1:0]        i_rs1_addr,
    input  logic [AW-1:0]        i_rs2_addr,
    input  logic [DW-1:0]        i_rs1_rf,
    input  logic [DW-1:0]        i_rs2_rf,
    output logic [DW-1:0]        o_rs1_data,
    output logic [DW-1:0]        o_rs2_data,
`endif
    output logic                 o_rd_wren,
    output logic [AW-1:0]        o_rd_addr,
    output logic [DW-1:0]        o_rd_data,
    output logic                 o_busy
);

    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW1 = PW + 1;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic            wren_q, wren_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;

    logic [NREQ-1:0] grant_s;
    logic            found_s;
    logic [AW-1:0]   win_addr_s;
    logic [DW-1:0]   win_data_s;
    logic [PW-1:0]   win_next_s;

    // Round-robin scan starting at the pointer; nothing is granted in reset or stall.
    always_comb begin
        logic [PW:0]   sum_v;
        logic [PW-1:0] cand_v;
        grant_s = '0;
        found_s = 1'b0;
        sum_v   = '0;
        cand_v  = '0;
        if (i_rst && !i_stall) begin
            for (int i = 0; i < NREQ; i++) begin
                sum_v = {1'b0, ptr_q} + PW1'(i);
                if (sum_v >= PW1'(NREQ)) begin
                    sum_v = sum_v - PW1'(NREQ);
                end else begin
                    sum_v = sum_v;
                end
                cand_v = sum_v[PW-1:0];
                if (!found_s && i_req_valid[cand_v]) begin
                    grant_s[cand_v] = 1'b1;
                    found_s         = 1'b1;
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            grant_s = '0;
        end
    end

    assign o_req_ready = grant_s;

    // Mux the one-hot winner's payload and its successor pointer.
    always_comb begin
        win_addr_s = '0;
        win_data_s = '0;
        win_next_s = '0;
        for (int k = 0; k < NREQ; k++) begin
            win_addr_s = win_addr_s | (i_req_addr[k*AW +: AW] & {AW{grant_s[k]}});
            win_data_s = win_data_s | (i_req_data[k*DW +: DW] & {DW{grant_s[k]}});
            win_next_s = win_next_s |
                         (grant_s[k] ? ((k == NREQ - 1) ? '0 : PW'(k + 1)) : '0);
        end
    end

    // Next-state for the output stage; a write to x0 is consumed but never enabled.
    always_comb begin
        ptr_d  = ptr_q;
        wren_d = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        if (|grant_s) begin
            ptr_d  = win_next_s;
            wren_d = (win_addr_s != '0);
            addr_d = win_addr_s;
            data_d = win_data_s;
        end else begin
            ptr_d  = ptr_q;
            wren_d = 1'b0;
        end
    end

    // Output stage and round-robin pointer.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ptr_q  <= '0;
            wren_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            wren_q <= wren_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign o_rd_wren = wren_q;
    assign o_rd_addr = addr_q;
    assign o_rd_data = data_q;
    assign o_busy    = wren_q;

`ifdef WB_FWD_EN
    // Bypass the pending write to readers of the same non-zero register.
    always_comb begin
        if (wren_q && (addr_q == i_rs1_addr) && (i_rs1_addr != '0)) begin
            o_rs1_data = data_q;
        end else begin
            o_rs1_data = i_rs1_rf;
        end
        if (wren_q && (addr_q == i_rs2_addr) && (i_rs2_addr != '0)) begin
            o_rs2_data = data_q;
        end else begin
            o_rs2_data = i_rs2_rf;
        end
    end
`endif

endmodule
